// File: rtl/dac_frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// dac_frame_rx_pkg
// Shared definitions for the DAC frame receiver: bank command encodings,
// broadcast address, frame field bit positions, FSM state type and the
// channel-select decode used by the register bank.
// -----------------------------------------------------------------------------
package dac_frame_rx_pkg;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 4;
    localparam int CMD_W  = 4;

    localparam logic [CMD_W-1:0] CMD_WRITE         = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_UPDATE        = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_WRITE_UPD_ALL = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_WRITE_UPD     = 4'b0011;

    localparam logic [ADDR_W-1:0] ADDR_ALL = 4'b1111;

    // Field positions inside a 32-bit frame (bit 31 is shifted in first).
    localparam int DATA_MSB = 27;
    localparam int DATA_LSB = 16;
    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 12;
    localparam int CMD_MSB  = 11;
    localparam int CMD_LSB  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    // One-hot channel select; addresses outside 0..3 and ADDR_ALL select nothing.
    function automatic logic [NUM_CH-1:0] addr_sel(input logic [ADDR_W-1:0] addr);
        logic [NUM_CH-1:0] sel;
        sel = '0;
        if (addr == ADDR_ALL) begin
            sel = '1;
        end else if (addr < ADDR_W'(NUM_CH)) begin
            sel[addr[1:0]] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dac_frame_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Multi-flop synchroniser for one asynchronous input, with single-cycle
// rising/falling edge strobes derived from the synchronised level.
//   clk   in   system clock
//   rst   in   async active-high reset (all stages cleared to 0)
//   din   in   asynchronous input
//   sync  out  synchronised level (STAGES flops deep)
//   rise  out  one-cycle strobe on a synchronised 0->1 transition
//   fall  out  one-cycle strobe on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge
    import dac_frame_rx_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
            prev <= 1'b0;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            prev <= pipe[STAGES-1];
        end
    end

    assign sync = pipe[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/dac_frame_rx.sv
// -----------------------------------------------------------------------------
// dac_frame_rx
// Receive-side DAC emulator: oversamples the SPI link in the clk domain,
// deserialises 32-bit frames (mode 0, MSB first), decodes data/addr/cmd and
// drives a four-channel input/DAC register bank.
//
// Ports
//   clk, rst               system clock, async active-high reset
//   spi_sck, spi_mosi      serial clock / data from the transmitter (async)
//   dac_cs                 frame select, active-low (async)
//   dac_clr                bank clear, active-low (async)
//   rx_valid / rx_err      one-cycle pulse: good frame / wrong bit count
//   rx_data/addr/cmd       fields of the last good frame
//   ch_a..ch_d             DAC registers of channels 0..3
//
// Build option
//   DAC_FRAME_RX_BANK_EN   defined: register bank present.
//                          undefined: no bank, ch_* tied to 0.
//
// FSM
//   state | meaning
//   IDLE  | cs high or re-arming; shift register and counter held clear
//   SHIFT | frame open; each sck rise shifts one bit, counter saturates
//   DONE  | one cycle after cs rose; verdict was registered on entry
// -----------------------------------------------------------------------------
module dac_frame_rx
    import dac_frame_rx_pkg::*;
#(
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              dac_cs,
    input  logic              dac_clr,
    output logic              rx_valid,
    output logic              rx_err,
    output logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [CMD_W-1:0]  rx_cmd,
    output logic [DATA_W-1:0] ch_a,
    output logic [DATA_W-1:0] ch_b,
    output logic [DATA_W-1:0] ch_c,
    output logic [DATA_W-1:0] ch_d
);

    localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
    localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);

    logic sck_rise;
    logic mosi_sync;
    logic cs_rise, cs_fall;
    logic clr_n_sync;

    logic unused_sck_sync, unused_sck_fall;
    logic unused_mosi_rise, unused_mosi_fall;
    logic unused_cs_sync;
    logic unused_clr_rise, unused_clr_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk (clk), .rst (rst), .din (spi_sck),
        .sync(unused_sck_sync), .rise(sck_rise), .fall(unused_sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk (clk), .rst (rst), .din (spi_mosi),
        .sync(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk (clk), .rst (rst), .din (dac_cs),
        .sync(unused_cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
        .clk (clk), .rst (rst), .din (dac_clr),
        .sync(clr_n_sync), .rise(unused_clr_rise), .fall(unused_clr_fall)
    );

    rx_state_t state, state_nxt;

    logic                  shift_en;
    logic                  cnt_clr;
    logic                  frame_ok;
    logic                  frame_bad;
    logic [FRAME_BITS-1:0] shreg;
    logic [5:0]            bit_cnt;

    logic [DATA_W-1:0] frame_data;
    logic [ADDR_W-1:0] frame_addr;
    logic [CMD_W-1:0]  frame_cmd;
    logic              unused_frame_msb;

    assign frame_data       = shreg[DATA_MSB:DATA_LSB];
    assign frame_addr       = shreg[ADDR_MSB:ADDR_LSB];
    assign frame_cmd        = shreg[CMD_MSB:CMD_LSB];
    assign unused_frame_msb = shreg[FRAME_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The verdict is taken on the SHIFT->DONE transition so that rx_valid,
    // the fields and the bank all change on the edge that enters DONE.
    // An sck edge coinciding with the cs rise is deliberately not shifted.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (!clr_n_sync) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (cs_fall) begin
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_nxt = DONE;
                        if (bit_cnt == CNT_FULL) begin
                            frame_ok = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end else if (sck_rise) begin
                        shift_en = 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_data  <= '0;
            rx_addr  <= '0;
            rx_cmd   <= '0;
        end else begin
            if (cnt_clr) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[FRAME_BITS-2:0], mosi_sync};
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
            rx_valid <= frame_ok;
            rx_err   <= frame_bad;
            if (frame_ok) begin
                rx_data <= frame_data;
                rx_addr <= frame_addr;
                rx_cmd  <= frame_cmd;
            end
        end
    end

`ifdef DAC_FRAME_RX_BANK_EN
    logic [DATA_W-1:0] in_reg  [NUM_CH];
    logic [DATA_W-1:0] dac_reg [NUM_CH];
    logic [NUM_CH-1:0] sel;

    assign sel = addr_sel(frame_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                in_reg[i]  <= '0;
                dac_reg[i] <= '0;
            end
        end else if (!clr_n_sync) begin
            for (int i = 0; i < NUM_CH; i++) begin
                in_reg[i]  <= '0;
                dac_reg[i] <= '0;
            end
        end else if (frame_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (frame_cmd)
                    CMD_WRITE: begin
                        if (sel[i]) in_reg[i] <= frame_data;
                    end
                    CMD_UPDATE: begin
                        if (sel[i]) dac_reg[i] <= in_reg[i];
                    end
                    CMD_WRITE_UPD_ALL: begin
                        // The freshly written channel must reach its DAC
                        // register in the same cycle, so bypass in_reg there.
                        if (|sel) begin
                            if (sel[i]) begin
                                in_reg[i]  <= frame_data;
                                dac_reg[i] <= frame_data;
                            end else begin
                                dac_reg[i] <= in_reg[i];
                            end
                        end
                    end
                    CMD_WRITE_UPD: begin
                        if (sel[i]) begin
                            in_reg[i]  <= frame_data;
                            dac_reg[i] <= frame_data;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign ch_a = dac_reg[0];
    assign ch_b = dac_reg[1];
    assign ch_c = dac_reg[2];
    assign ch_d = dac_reg[3];
`else
    assign ch_a = '0;
    assign ch_b = '0;
    assign ch_c = '0;
    assign ch_d = '0;
`endif

endmodule

// File: tb/tb_dac_frame_rx.sv
`timescale 1ns/1ps
module tb_dac_frame_rx;

    localparam int SYNC_STAGES = 2;
    localparam int FRAME_BITS  = 32;
    localparam int LAT         = SYNC_STAGES + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        dac_cs = 1'b1;
    logic        dac_clr = 1'b1;
    logic        rx_valid, rx_err;
    logic [11:0] rx_data;
    logic [3:0]  rx_addr, rx_cmd;
    logic [11:0] ch_a, ch_b, ch_c, ch_d;

    dac_frame_rx #(.FRAME_BITS(FRAME_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .dac_cs(dac_cs), .dac_clr(dac_clr),
        .rx_valid(rx_valid), .rx_err(rx_err),
        .rx_data(rx_data), .rx_addr(rx_addr), .rx_cmd(rx_cmd),
        .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled on the falling edge
    int vcnt = 0, ecnt = 0, both_cnt = 0;
    int v_last = -1, v_prev = -1, ev_last = -1;
    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt   <= vcnt + 1;
            v_prev <= v_last;
            v_last <= cyc;
        end
        if (rx_err) ecnt <= ecnt + 1;
        if (rx_valid || rx_err) ev_last <= cyc;
        if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
    end

    int n_cmp = 0, n_mis = 0;

    // reference model: last good fields and the channel bank
    logic [11:0] m_data = '0;
    logic [3:0]  m_addr = '0, m_cmd = '0;
    int          m_in [4];
    int          m_dac[4];

    task automatic model_reset();
        m_data = '0; m_addr = '0; m_cmd = '0;
        for (int i = 0; i < 4; i++) begin m_in[i] = 0; m_dac[i] = 0; end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin m_in[i] = 0; m_dac[i] = 0; end
    endtask

    task automatic model_frame(input int data, input int addr, input int cmd);
        m_data = 12'(data); m_addr = 4'(addr); m_cmd = 4'(cmd);
        if (addr <= 3 || addr == 15) begin
            for (int i = 0; i < 4; i++) begin
                if (addr == 15 || addr == i) begin
                    if (cmd == 0 || cmd == 2) m_in[i] = data;
                    if (cmd == 1) m_dac[i] = m_in[i];
                    if (cmd == 3) begin m_in[i] = data; m_dac[i] = data; end
                end
            end
            if (cmd == 2) for (int i = 0; i < 4; i++) m_dac[i] = m_in[i];
        end
    endtask

    function automatic logic [11:0] exp_ch(input int i);
`ifdef DAC_FRAME_RX_BANK_EN
        return 12'(m_dac[i]);
`else
        return 12'h000;
`endif
    endfunction

    function automatic logic [11:0] dut_ch(input int i);
        case (i)
            0: return ch_a;
            1: return ch_b;
            2: return ch_c;
            default: return ch_d;
        endcase
    endfunction

    function automatic logic [31:0] mk(input int dc4, input int data, input int addr,
                                       input int cmd, input int dc8);
        return {4'(dc4), 12'(data), 4'(addr), 4'(cmd), 8'(dc8)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [39:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            tick(2);
            spi_sck = 1'b1;
            tick(2);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [39:0] bits, input int nbits, output int c0);
        dac_cs = 1'b0;
        tick(2);
        send_bits(bits, nbits);
        tick(2);
        dac_cs = 1'b1;
        c0 = cyc;
        tick(8);
    endtask

    task automatic test_reset();
        logic [67:0] all_out;
        rst = 1'b1;
        tick(3);
        all_out = {rx_valid, rx_err, rx_data, rx_addr, rx_cmd, ch_a, ch_b, ch_c, ch_d};
        n_cmp++;
        if (all_out !== '0) begin n_mis++; $display("FAIL reset_during: outputs=%h want 0", all_out); end
        rst = 1'b0;
        tick(5);
        all_out = {rx_valid, rx_err, rx_data, rx_addr, rx_cmd, ch_a, ch_b, ch_c, ch_d};
        n_cmp++;
        if (all_out !== '0) begin n_mis++; $display("FAIL reset_after: outputs=%h want 0", all_out); end
        model_reset();
    endtask

    task automatic test_single();
        int v0, e0, c0;
        v0 = vcnt; e0 = ecnt;
        run_frame({8'h0, mk(0, 12'hABC, 1, 3, 0)}, 32, c0);
        model_frame(12'hABC, 1, 3);
        n_cmp++;
        if (vcnt - v0 !== 1 || ecnt !== e0) begin n_mis++; $display("FAIL single_pulses: valid=%0d err=%0d want 1/0", vcnt - v0, ecnt - e0); end
        n_cmp++;
        if ({rx_data, rx_addr, rx_cmd} !== {12'hABC, 4'h1, 4'h3}) begin n_mis++; $display("FAIL single_fields: got %h/%h/%h want abc/1/3", rx_data, rx_addr, rx_cmd); end
        n_cmp++;
        if (v_last - c0 !== LAT) begin n_mis++; $display("FAIL single_latency: got %0d want %0d", v_last - c0, LAT); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_ch(i) !== exp_ch(i)) begin n_mis++; $display("FAIL single_ch%0d: got %h want %h", i, dut_ch(i), exp_ch(i)); end
        end
    endtask

    task automatic test_write_update();
        int c0;
        run_frame({8'h0, mk(0, 12'h123, 2, 0, 0)}, 32, c0);
        model_frame(12'h123, 2, 0);
        n_cmp++;
        if (ch_c !== exp_ch(2) || ch_c !== 12'h000) begin n_mis++; $display("FAIL write_only_ch_c: got %h want 000", ch_c); end
        run_frame({8'h0, mk(0, 12'h000, 2, 1, 0)}, 32, c0);
        model_frame(12'h000, 2, 1);
        n_cmp++;
        if (ch_c !== exp_ch(2)) begin n_mis++; $display("FAIL update_ch_c: got %h want %h", ch_c, exp_ch(2)); end
    endtask

    task automatic test_broadcast_clear();
        int c0;
        run_frame({8'h0, mk(4'hF, 12'hFFF, 15, 3, 8'hFF)}, 32, c0);
        model_frame(12'hFFF, 15, 3);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_ch(i) !== exp_ch(i)) begin n_mis++; $display("FAIL bcast_ch%0d: got %h want %h", i, dut_ch(i), exp_ch(i)); end
        end
        dac_clr = 1'b0;
        tick(3);
        dac_clr = 1'b1;
        tick(4);
        model_clear();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_ch(i) !== 12'h000) begin n_mis++; $display("FAIL clear_ch%0d: got %h want 000", i, dut_ch(i)); end
        end
    endtask

    task automatic test_clear_abort();
        int v0, e0, c0;
        logic [31:0] f;
        f = mk(0, 12'h5A5, 0, 3, 0);
        v0 = vcnt; e0 = ecnt;
        dac_cs = 1'b0;
        tick(2);
        send_bits({8'h0, f} >> 22, 10);
        dac_clr = 1'b0;
        tick(3);
        dac_clr = 1'b1;
        send_bits({8'h0, f}, 22);
        tick(2);
        dac_cs = 1'b1;
        tick(8);
        model_clear();
        n_cmp++;
        if (vcnt !== v0 || ecnt !== e0) begin n_mis++; $display("FAIL clear_abort: valid=%0d err=%0d want 0/0", vcnt - v0, ecnt - e0); end
        run_frame({8'h0, mk(0, 12'h246, 0, 3, 0)}, 32, c0);
        model_frame(12'h246, 0, 3);
        n_cmp++;
        if (vcnt - v0 !== 1 || rx_data !== 12'h246 || ch_a !== exp_ch(0)) begin
            n_mis++; $display("FAIL clear_rearm: valid=%0d data=%h ch_a=%h want 1/246/%h", vcnt - v0, rx_data, ch_a, exp_ch(0));
        end
    endtask

    task automatic test_bad_count();
        int v0, e0, c0;
        logic [31:0] f;
        f = mk(0, 12'h777, 3, 3, 0);
        v0 = vcnt; e0 = ecnt;
        run_frame({8'h0, f} >> 1, 31, c0);
        n_cmp++;
        if (ecnt - e0 !== 1 || vcnt !== v0) begin n_mis++; $display("FAIL short_frame: err=%0d valid=%0d want 1/0", ecnt - e0, vcnt - v0); end
        n_cmp++;
        if (ev_last - c0 !== LAT) begin n_mis++; $display("FAIL short_latency: got %0d want %0d", ev_last - c0, LAT); end
        run_frame({7'h0, f, 1'b1}, 33, c0);
        n_cmp++;
        if (ecnt - e0 !== 2 || vcnt !== v0) begin n_mis++; $display("FAIL long_frame: err=%0d valid=%0d want 2/0", ecnt - e0, vcnt - v0); end
        n_cmp++;
        if ({rx_data, rx_addr, rx_cmd} !== {m_data, m_addr, m_cmd}) begin n_mis++; $display("FAIL bad_fields: got %h/%h/%h want %h/%h/%h", rx_data, rx_addr, rx_cmd, m_data, m_addr, m_cmd); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_ch(i) !== exp_ch(i)) begin n_mis++; $display("FAIL bad_ch%0d: got %h want %h", i, dut_ch(i), exp_ch(i)); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0, c0;
        logic [31:0] f;
        f = mk(0, 12'hDEF, 3, 3, 0);
        dac_cs = 1'b0;
        tick(2);
        send_bits({8'h0, f} >> 16, 16);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(4);
        v0 = vcnt; e0 = ecnt;
        dac_cs = 1'b1;
        tick(8);
        n_cmp++;
        if (vcnt !== v0 || ecnt !== e0 || rx_data !== 12'h000 || ch_d !== 12'h000) begin
            n_mis++; $display("FAIL rst_mid_discard: valid=%0d err=%0d data=%h ch_d=%h want 0/0/000/000", vcnt - v0, ecnt - e0, rx_data, ch_d);
        end
        run_frame({8'h0, mk(0, 12'h9C1, 3, 3, 0)}, 32, c0);
        model_frame(12'h9C1, 3, 3);
        n_cmp++;
        if (vcnt - v0 !== 1 || {rx_data, rx_addr, rx_cmd} !== {12'h9C1, 4'h3, 4'h3} || ch_d !== exp_ch(3)) begin
            n_mis++; $display("FAIL rst_mid_next: valid=%0d fields=%h/%h/%h ch_d=%h want 1/9c1/3/3/%h", vcnt - v0, rx_data, rx_addr, rx_cmd, ch_d, exp_ch(3));
        end
    endtask

    task automatic test_back_to_back();
        int v0, c0, c1;
        v0 = vcnt;
        dac_cs = 1'b0;
        tick(2);
        send_bits({8'h0, mk(0, 12'h111, 0, 0, 0)}, 32);
        tick(2);
        dac_cs = 1'b1;
        c0 = cyc;
        tick(2);
        dac_cs = 1'b0;
        tick(2);
        send_bits({8'h0, mk(0, 12'h222, 15, 2, 0)}, 32);
        tick(2);
        dac_cs = 1'b1;
        c1 = cyc;
        tick(8);
        model_frame(12'h111, 0, 0);
        model_frame(12'h222, 15, 2);
        n_cmp++;
        if (vcnt - v0 !== 2) begin n_mis++; $display("FAIL b2b_count: got %0d want 2", vcnt - v0); end
        n_cmp++;
        if (v_prev - c0 !== LAT || v_last - c1 !== LAT) begin n_mis++; $display("FAIL b2b_latency: got %0d,%0d want %0d", v_prev - c0, v_last - c1, LAT); end
        n_cmp++;
        if ({rx_data, rx_addr, rx_cmd} !== {12'h222, 4'hF, 4'h2}) begin n_mis++; $display("FAIL b2b_fields: got %h/%h/%h want 222/f/2", rx_data, rx_addr, rx_cmd); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_ch(i) !== exp_ch(i)) begin n_mis++; $display("FAIL b2b_ch%0d: got %h want %h", i, dut_ch(i), exp_ch(i)); end
        end
    endtask

    task automatic test_random();
        int v0, e0, c0, data, addr, cmd, nbits, r;
        logic [31:0] f;
        logic [39:0] bits;
        for (int k = 0; k < 24; k++) begin
            data = $urandom_range(0, 4095);
            r = $urandom_range(0, 5);
            addr = (r <= 3) ? r : (r == 4) ? 15 : $urandom_range(4, 14);
            cmd = $urandom_range(0, 5);
            f = mk($urandom_range(0, 15), data, addr, cmd, $urandom_range(0, 255));
            r = $urandom_range(0, 9);
            nbits = (r == 0) ? 31 : (r == 1) ? 33 : 32;
            bits = (nbits == 31) ? ({8'h0, f} >> 1) : (nbits == 33) ? {7'h0, f, 1'($urandom_range(0, 1))} : {8'h0, f};
            v0 = vcnt; e0 = ecnt;
            run_frame(bits, nbits, c0);
            if (nbits == 32) model_frame(data, addr, cmd);
            n_cmp++;
            if (vcnt - v0 !== int'(nbits == 32) || ecnt - e0 !== int'(nbits != 32)) begin
                n_mis++; $display("FAIL rnd%0d_pulses: valid=%0d err=%0d nbits=%0d", k, vcnt - v0, ecnt - e0, nbits);
            end
            n_cmp++;
            if (ev_last - c0 !== LAT) begin n_mis++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, ev_last - c0, LAT); end
            n_cmp++;
            if ({rx_data, rx_addr, rx_cmd} !== {m_data, m_addr, m_cmd}) begin
                n_mis++; $display("FAIL rnd%0d_fields: got %h/%h/%h want %h/%h/%h", k, rx_data, rx_addr, rx_cmd, m_data, m_addr, m_cmd);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (dut_ch(i) !== exp_ch(i)) begin n_mis++; $display("FAIL rnd%0d_ch%0d: got %h want %h", k, i, dut_ch(i), exp_ch(i)); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_write_update();
        test_broadcast_clear();
        test_bad_count();
        test_clear_abort();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (both_cnt !== 0) begin n_mis++; $display("FAIL valid_err_overlap: got %0d cycles want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dac_frame_rx.md
# dac_frame_rx

Receive-side model of the DAC serial link: oversamples the SPI lines (`spi_sck`, `spi_mosi`, `dac_cs`, `dac_clr`) in the system clock domain. It deserialises each 32-bit DAC frame, decodes the data, channel and command fields, and keeps a four-channel DAC register bank. It sits at the far end of the DAC transmitter. It serves as a synthesizable DAC emulator for loopback on the board and as the checker in simulation benches.

## Interface
- `FRAME_BITS`, 32: bits per frame; a frame is valid only when exactly this many bits arrive.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronisers (minimum 2).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `spi_sck`  in  1  serial clock from the transmitter; asynchronous to `clk`.
- `spi_mosi`  in  1  serial data, MSB first.
- `dac_cs`  in  1  frame select, active-low.
- `dac_clr`  in  1  DAC clear, active-low.
- `rx_valid`  out  1  one-cycle pulse when a well-formed frame completes.
- `rx_err`  out  1  one-cycle pulse when a frame ends with the wrong bit count.
- `rx_data`  out  12  data field of the last valid frame.
- `rx_addr`  out  4  channel field of the last valid frame.
- `rx_cmd`  out  4  command field of the last valid frame.
- `ch_a`, `ch_b`, `ch_c`, `ch_d`  out  12 each  DAC output registers for channels 0–3.

## Operation
- **Inputs:** all four inputs pass through `SYNC_STAGES` synchronisers. A rising edge of `spi_sck` is detected on the synchronised signal by comparing it with a one-cycle-delayed copy. SPI mode 0: a bit is sampled on the rising `spi_sck` edge.
- **Frame layout** (bit 31 arrives first):
  - [31:28]: don't care.
  - [27:16]: data.
  - [15:12]: addr.
  - [11:8]: cmd.
  - [7:0]: don't care.
- **FSM states:**
  - IDLE: cs high. Shift register and bit counter are cleared. Moves to SHIFT on the synchronised falling edge of cs.
  - SHIFT: each detected sck rising edge shifts `spi_mosi` into a 32-bit register and increments a 6-bit counter. The counter saturates at `FRAME_BITS`+1. Moves to DONE on the synchronised rising edge of cs.
  - DONE: lasts one cycle, then returns to IDLE.
    - If count == `FRAME_BITS`: latch `rx_data`, `rx_addr` and `rx_cmd`, pulse `rx_valid`, apply the command to the bank.
    - Otherwise: pulse `rx_err`; fields and bank are unchanged.
  - An sck edge in the same cycle as the cs rising edge is not counted.
- **Bank commands:** each channel has an input register and a DAC register; `ch_*` show the DAC registers.
  - 0000: write the input register selected by addr.
  - 0001: copy input register to DAC register for addr.
  - 0010: write the input register for addr, then copy all input registers to their DAC registers.
  - 0011: write the input register for addr and copy it to the DAC register.
  - Any other cmd: no effect.
  - addr 0–3 selects one channel; 1111 selects all channels; any other addr has no effect on the bank.
- **Clear:** while synchronised `dac_clr` is 0:
  - all input and DAC registers are held at 0;
  - any frame in progress is aborted to IDLE, with no `rx_err`;
  - the FSM re-arms only after cs is seen falling again.
- **Reset:** the FSM goes to IDLE and every register, including synchroniser stages, is set to 0. All outputs read 0 during and after reset. Reset in the middle of a frame discards the frame.

## Timing
- `clk` must be at least 4× the `spi_sck` frequency. `spi_sck` high and low times must each be at least 2 `clk` periods. cs setup and hold around sck edges must be at least 2 `clk` periods.
- **Latency:** the cs rising edge at the pin reaches DONE `SYNC_STAGES`+1 `clk` edges later. `rx_valid`, the field outputs and `ch_*` update on that edge.
- `rx_valid` and `rx_err` are mutually exclusive and each is high for exactly one cycle.
- Back-to-back frames with a cs-high gap of 2 `clk` cycles or more are all received.

## Configuration
- `DAC_FRAME_RX_BANK_EN`:
  - Defined: the register bank is built and `ch_a`…`ch_d` behave as described above.
  - Undefined: no bank is built and `ch_*` are tied to 0. Frame decoding, `rx_*` outputs and the effect of `dac_clr` on framing are unchanged.

## Structure
- A shared package holds:
  - the command encodings (`CMD_WRITE`, `CMD_UPDATE`, `CMD_WRITE_UPD_ALL`, `CMD_WRITE_UPD`);
  - `ADDR_ALL` = 4'b1111;
  - the field bit positions;
  - the FSM state constants (IDLE, SHIFT, DONE).
- One sub-module, `sync_edge`: a parameterised-depth synchroniser with rising-edge and falling-edge outputs. It is instantiated once per input line.

## Test plan
- Reset, then frame {4'h0, 12'hABC, 4'h1, 4'h3, 8'h00} → one `rx_valid` pulse; `rx_data`=ABC, `rx_addr`=1, `rx_cmd`=3; `ch_b`=ABC; the other channels stay 0.
- Frame cmd 0 / addr 2 / data 123, then frame cmd 1 / addr 2 → `ch_c` is 0 after the first frame and 123 after the second.
- Frame with addr F, cmd 3, data FFF → all four `ch_*` = FFF. Then drive `dac_clr` low for 3 cycles → all `ch_*` = 0.
- 31-bit frame and 33-bit frame → one `rx_err` pulse each, no `rx_valid`, fields and bank unchanged.
- Assert `rst` after 16 bits, release it, then send a full frame → only the second frame produces `rx_valid`, with correct fields.
- Two frames with a 2-cycle cs gap and sck = `clk`/4 → two `rx_valid` pulses, each `SYNC_STAGES`+1 cycles after its cs rising edge.
